id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register that sits directly upstream of the 32-bit ALU and drives its s, t and 4-bit control inputs. It decodes the MIPS instruction into the ALU control code (0h AND, 1h OR, 2h ADD, 6h SUB, 7h SLT, Ch NOR) and forwards operands from later stages. It detects load-use hazards and registers everything for the EX cycle, with hold, flush and bubble insertion.

Parameters:
FWD_EN, 1, 1 enables operand forwarding; 0 always uses register-file data (hazard logic still active).

Ports:
clk  in  1  rising-edge clock (same clock as the ALU)
rst_n  in  1  synchronous active-low reset
id_valid  in  1  id_instr holds a real instruction
id_instr  in  32  instruction word in ID
id_rs_data  in  32  register-file read of rs
id_rt_data  in  32  register-file read of rt
hold  in  1  downstream stall; register keeps its contents
flush  in  1  squash; register loads a bubble
alu_result  in  32  combinational ALU result for the instruction currently in EX
mem_wr_en  in  1  MEM-stage instruction writes a register
mem_rd  in  5  MEM-stage destination
mem_data  in  32  MEM-stage result
wb_wr_en  in  1  WB-stage instruction writes a register
wb_rd  in  5  WB-stage destination
wb_data  in  32  WB-stage write data
id_stall  out  1  upstream (PC, IF/ID) must freeze this cycle; combinational
ex_valid  out  1  EX slot holds a real instruction
ex_s  out  32  ALU operand s
ex_t  out  32  ALU operand t
ex_control  out  4  ALU control code
ex_store_data  out  32  forwarded rt value for sw
ex_rd  out  5  destination register
ex_reg_write  out  1  instruction writes ex_rd
ex_mem_read  out  1  load (lw)
ex_mem_write  out  1  store (sw)
ex_branch  out  1  beq; the ALU zero flag resolves the branch
ex_illegal  out  1  unsupported opcode or funct

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0. It has priority over every other input.
- Register update priority per edge: reset > flush (bubble) > hold (keep) > hazard (bubble) > load decoded ID.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal = 0. All data fields 0.
- Latency: 1 cycle from ID to the outputs. Outputs are registered only.
- R-type (op 00h) funct decode:
  - 20h/21h → 2
  - 22h/23h → 6
  - 24h → 0
  - 25h → 1
  - 27h → C
  - 2Ah → 7
  - ex_rd = instr[15:11], reg_write = 1, t = rt.
- I-type decode (dest = rt, t = immediate):
  - addi 08h / addiu 09h → 2, sign-extended immediate
  - slti 0Ah → 7, sign-extended immediate
  - andi 0Ch → 0, zero-extended immediate
  - ori 0Dh → 1, zero-extended immediate
  - lw 23h → 2, sign-extended immediate, mem_read = 1
  - sw 2Bh → 2, sign-extended immediate, mem_write = 1, reg_write = 0
  - beq 04h → 6, t = rt, branch = 1, reg_write = 0
- Illegal instruction: anything else loads valid = 1, illegal = 1, reg_write/mem_* = 0, control = 0.
- Writes to register 0: reg_write is forced to 0 whenever the destination is register 0.
- Forwarding for rs and rt separately. Register 0 is never forwarded (always reads 0). Priority:
  1. EX: ex_valid & ex_reg_write & !ex_mem_read & ex_rd match → alu_result
  2. MEM: mem_wr_en & mem_rd match → mem_data
  3. WB: wb_wr_en & wb_rd match → wb_data
  4. otherwise register-file data
- Load-use hazard = id_valid & ex_valid & ex_mem_read & ex_rd≠0 & (ex_rd==rs, or ex_rd==rt for R-type/beq/sw).
- id_stall = hold | (hazard & !flush).
- During a hazard a bubble enters EX and the ID instruction is re-presented next cycle. On that cycle the load sits in MEM and is forwarded from mem_data.
- id_valid=0 with no hold loads a bubble.
- hold and flush together: flush wins and id_stall = hold.

Decomposition:
- Shared package mips_pkg: ALU code constants (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=C), opcode and funct constants. The ALU and this block use the same constants.
- One sub-module, alu_ctrl_decode: combinational instr → control, rd, write/mem/branch/illegal flags, and immediate-extension select.
- Forwarding, hazard logic and the register stay in id_ex_stage.

Test Plan:
1. Reset mid-stream: rst_n=0 for one edge with valid add loaded → all outputs 0 next cycle; id_stall=0.
2. add $3,$1,$2 with rs_data=5, rt_data=7 → next cycle ex_control=2, ex_s=5, ex_t=7, ex_rd=3, ex_reg_write=1.
3. andi $4,$1,0xFFFF, then addi $4,$1,-1 with rs_data=0 → ex_t=0000FFFF, then ex_t=FFFFFFFF.
4. Forwarding priority: sub $5,$2,$2 in EX (alu_result=0), mem_rd=2 with mem_data=9, next instr rs=2 → ex_s=0. With EX not matching → ex_s=9. Register 0 sources → ex_s=0 even if mem_rd=0.
5. lw $6,0($1) in EX, then add $7,$6,$6 in ID → id_stall=1 for one cycle and a bubble enters EX. Next cycle, with mem_rd=6, mem_data=42 → ex_s=ex_t=42, id_stall=0.
6. Unsupported funct 3Fh → ex_valid=1, ex_illegal=1, ex_reg_write=0. Then flush with hold=1 → bubble loaded, id_stall=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and types used by the ID/EX stage and the ALU.
package mips_pkg;

   // ALU control codes
   localparam logic [3:0] ALU_AND = 4'h0;
   localparam logic [3:0] ALU_OR  = 4'h1;
   localparam logic [3:0] ALU_ADD = 4'h2;
   localparam logic [3:0] ALU_SUB = 4'h6;
   localparam logic [3:0] ALU_SLT = 4'h7;
   localparam logic [3:0] ALU_NOR = 4'hC;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   // Source of ALU operand t
   typedef enum logic [1:0] {
      IMM_NONE = 2'd0,   // t comes from rt
      IMM_SEXT = 2'd1,
      IMM_ZEXT = 2'd2
   } imm_sel_e;

   // Decoder output
   typedef struct packed {
      logic [3:0] control;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       illegal;
      logic       uses_rt;   // rt is a source operand (load-use relevant)
      imm_sel_e   imm_sel;
   } dec_t;

   // Contents of the EX slot
   typedef struct packed {
      logic        valid;
      logic [31:0] s;
      logic [31:0] t;
      logic [31:0] store_data;
      logic [3:0]  control;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        illegal;
   } ex_reg_t;

   function automatic logic [31:0] ext_imm(input logic [15:0] imm, input imm_sel_e sel);
      return (sel == IMM_ZEXT) ? {16'h0000, imm} : {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS decode: instruction fields -> ALU control, destination and flags.
module alu_ctrl_decode
   import mips_pkg::*;
(
   input  logic [5:0] op,
   input  logic [4:0] rt,
   input  logic [4:0] rd,
   input  logic [5:0] funct,
   output dec_t       dec
);

   // Decode opcode/funct; unknown encodings fall through as illegal with no side effects
   always_comb begin
      dec         = '0;
      dec.imm_sel = IMM_NONE;
      case (op)
         OP_RTYPE: begin
            dec.rd        = rd;
            dec.reg_write = 1'b1;
            dec.uses_rt   = 1'b1;
            case (funct)
               FN_ADD, FN_ADDU: dec.control = ALU_ADD;
               FN_SUB, FN_SUBU: dec.control = ALU_SUB;
               FN_AND:          dec.control = ALU_AND;
               FN_OR:           dec.control = ALU_OR;
               FN_NOR:          dec.control = ALU_NOR;
               FN_SLT:          dec.control = ALU_SLT;
               default: begin
                  dec.illegal   = 1'b1;
                  dec.rd        = '0;
                  dec.reg_write = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            dec.control = ALU_ADD; dec.rd = rt; dec.reg_write = 1'b1; dec.imm_sel = IMM_SEXT;
         end
         OP_SLTI: begin
            dec.control = ALU_SLT; dec.rd = rt; dec.reg_write = 1'b1; dec.imm_sel = IMM_SEXT;
         end
         OP_ANDI: begin
            dec.control = ALU_AND; dec.rd = rt; dec.reg_write = 1'b1; dec.imm_sel = IMM_ZEXT;
         end
         OP_ORI: begin
            dec.control = ALU_OR; dec.rd = rt; dec.reg_write = 1'b1; dec.imm_sel = IMM_ZEXT;
         end
         OP_LW: begin
            dec.control = ALU_ADD; dec.rd = rt; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
            dec.imm_sel = IMM_SEXT;
         end
         OP_SW: begin
            dec.control = ALU_ADD; dec.mem_write = 1'b1; dec.uses_rt = 1'b1;
            dec.imm_sel = IMM_SEXT;
         end
         OP_BEQ: begin
            dec.control = ALU_SUB; dec.branch = 1'b1; dec.uses_rt = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      // $0 is hardwired; never claim a write to it
      if (dec.rd == 5'd0) dec.reg_write = 1'b0;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: decode, forwarding, load-use hazard, hold/flush.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [31:0] id_instr,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] alu_result,
   input  logic        mem_wr_en,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   input  logic        wb_wr_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        id_stall,
   output logic        ex_valid,
   output logic [31:0] ex_s,
   output logic [31:0] ex_t,
   output logic [3:0]  ex_control,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_rd,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_branch,
   output logic        ex_illegal
);

   logic [4:0]  rs, rt;
   logic [15:0] imm;
   dec_t        dec;
   ex_reg_t     ex_q, ex_d;
   logic [31:0] rs_fwd, rt_fwd;
   logic        hazard;

   assign rs  = id_instr[25:21];
   assign rt  = id_instr[20:16];
   assign imm = id_instr[15:0];

   alu_ctrl_decode u_dec (
      .op    (id_instr[31:26]),
      .rt    (rt),
      .rd    (id_instr[15:11]),
      .funct (id_instr[5:0]),
      .dec   (dec)
   );

   // Youngest producer wins; a load in EX has no data yet and is handled by the hazard stall
   function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
      if (!FWD_EN)                                                          return rf;
      if (src == 5'd0)                                                      return '0;
      if (ex_q.valid && ex_q.reg_write && !ex_q.mem_read && ex_q.rd == src) return alu_result;
      if (mem_wr_en && mem_rd == src)                                       return mem_data;
      if (wb_wr_en && wb_rd == src)                                         return wb_data;
      return rf;
   endfunction

   // Operand selection and next EX contents
   always_comb begin
      rs_fwd           = fwd(rs, id_rs_data);
      rt_fwd           = fwd(rt, id_rt_data);
      ex_d             = '0;
      ex_d.valid       = 1'b1;
      ex_d.s           = rs_fwd;
      ex_d.t           = (dec.imm_sel == IMM_NONE) ? rt_fwd : ext_imm(imm, dec.imm_sel);
      ex_d.store_data  = rt_fwd;
      ex_d.control     = dec.control;
      ex_d.rd          = dec.rd;
      ex_d.reg_write   = dec.reg_write;
      ex_d.mem_read    = dec.mem_read;
      ex_d.mem_write   = dec.mem_write;
      ex_d.branch      = dec.branch;
      ex_d.illegal     = dec.illegal;
   end

   // Load-use: the consumer must wait one cycle so the load data can come from MEM
   assign hazard = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                   ((ex_q.rd == rs) || (dec.uses_rt && ex_q.rd == rt));

   assign id_stall = hold || (hazard && !flush);

   // EX slot register: reset > flush > hold > hazard/empty ID > load
   always_ff @(posedge clk) begin
      if (!rst_n)                     ex_q <= '0;
      else if (flush)                 ex_q <= '0;
      else if (hold)                  ex_q <= ex_q;
      else if (hazard || !id_valid)   ex_q <= '0;
      else                            ex_q <= ex_d;
   end

   assign ex_valid      = ex_q.valid;
   assign ex_s          = ex_q.s;
   assign ex_t          = ex_q.t;
   assign ex_control    = ex_q.control;
   assign ex_store_data = ex_q.store_data;
   assign ex_rd         = ex_q.rd;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_branch     = ex_q.branch;
   assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n, id_valid, hold, flush, mem_wr_en, wb_wr_en;
   logic [31:0] id_instr, id_rs_data, id_rt_data, alu_result, mem_data, wb_data;
   logic [4:0]  mem_rd, wb_rd;
   logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
   logic [31:0] ex_s, ex_t, ex_store_data;
   logic [3:0]  ex_control;
   logic [4:0]  ex_rd;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.FWD_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .hold(hold), .flush(flush),
      .alu_result(alu_result), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data), .id_stall(id_stall),
      .ex_valid(ex_valid), .ex_s(ex_s), .ex_t(ex_t), .ex_control(ex_control),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .ex_illegal(ex_illegal)
   );

   function automatic logic [31:0] rtype(input logic [4:0] s, t, d, input logic [5:0] fn);
      return {6'h00, s, t, d, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t,
                                         input logic [15:0] im);
      return {op, s, t, im};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      id_valid = 1'b1; id_instr = ins; id_rs_data = a; id_rt_data = b;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; step(); step();
      checks++;
      if ({ex_valid, ex_s, ex_t, ex_control, ex_store_data, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_branch, ex_illegal, id_stall} !== '0) begin
         errors++; $display("FAIL reset_init: outputs not all zero (valid=%b s=%h)", ex_valid, ex_s);
      end
      rst_n = 1'b1;
      drive(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7); step();
      checks++;
      if (ex_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", ex_valid); end
      rst_n = 1'b0; step(); #2;
      checks++;
      if ({ex_valid, ex_s, ex_t, ex_control, ex_store_data, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_branch, ex_illegal, id_stall} !== '0) begin
         errors++; $display("FAIL reset_mid: outputs not zero (valid=%b s=%h stall=%b)", ex_valid, ex_s, id_stall);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_rtype();
      logic [5:0] fns  [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
      logic [3:0] ctls [8] = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h0, 4'h1, 4'hC, 4'h7};
      drive(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7); step();
      checks++; if (ex_control !== 4'h2) begin errors++; $display("FAIL add_ctl: got %h want 2", ex_control); end
      checks++; if (ex_s !== 32'd5) begin errors++; $display("FAIL add_s: got %h want 5", ex_s); end
      checks++; if (ex_t !== 32'd7) begin errors++; $display("FAIL add_t: got %h want 7", ex_t); end
      checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL add_rd: got %0d want 3", ex_rd); end
      checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL add_rw: got %b want 1", ex_reg_write); end
      for (int i = 0; i < 8; i++) begin
         drive(rtype(5'd1, 5'd2, 5'd3, fns[i]), 32'd5, 32'd7); step();
         checks++;
         if (ex_control !== ctls[i]) begin
            errors++; $display("FAIL funct_%h: ctl got %h want %h", fns[i], ex_control, ctls[i]);
         end
      end
   endtask

   task automatic test_imm();
      drive(itype(6'h0C, 5'd1, 5'd4, 16'hFFFF), 32'd0, 32'd99); step();
      checks++; if (ex_t !== 32'h0000FFFF) begin errors++; $display("FAIL andi_t: got %h want 0000ffff", ex_t); end
      checks++; if (ex_control !== 4'h0) begin errors++; $display("FAIL andi_ctl: got %h want 0", ex_control); end
      drive(itype(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'd0, 32'd99); step();
      checks++; if (ex_t !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_t: got %h want ffffffff", ex_t); end
      checks++; if (ex_rd !== 5'd4 || ex_reg_write !== 1'b1) begin
         errors++; $display("FAIL addi_rd: got rd=%0d rw=%b want 4/1", ex_rd, ex_reg_write); end
      drive(itype(6'h0D, 5'd1, 5'd4, 16'h8000), 32'd0, 32'd0); step();
      checks++; if ({ex_control, ex_t} !== {4'h1, 32'h00008000}) begin
         errors++; $display("FAIL ori: got ctl=%h t=%h want 1/00008000", ex_control, ex_t); end
      drive(itype(6'h0A, 5'd1, 5'd4, 16'h8000), 32'd0, 32'd0); step();
      checks++; if ({ex_control, ex_t} !== {4'h7, 32'hFFFF8000}) begin
         errors++; $display("FAIL slti: got ctl=%h t=%h want 7/ffff8000", ex_control, ex_t); end
      drive(itype(6'h08, 5'd1, 5'd0, 16'd5), 32'd0, 32'd0); step();
      checks++; if ({ex_valid, ex_reg_write} !== 2'b10) begin
         errors++; $display("FAIL addi_r0: got valid=%b rw=%b want 1/0", ex_valid, ex_reg_write); end
   endtask

   task automatic test_mem_branch();
      drive(itype(6'h2B, 5'd1, 5'd5, 16'd4), 32'd100, 32'd200); step();
      checks++;
      if ({ex_control, ex_mem_write, ex_reg_write, ex_mem_read} !== {4'h2, 3'b100}) begin
         errors++; $display("FAIL sw_flags: got ctl=%h mw=%b rw=%b mr=%b want 2/1/0/0",
                            ex_control, ex_mem_write, ex_reg_write, ex_mem_read);
      end
      checks++; if ({ex_s, ex_t, ex_store_data} !== {32'd100, 32'd4, 32'd200}) begin
         errors++; $display("FAIL sw_data: got s=%h t=%h sd=%h want 64/4/c8", ex_s, ex_t, ex_store_data); end
      drive(itype(6'h04, 5'd1, 5'd2, 16'd3), 32'd10, 32'd20); step();
      checks++;
      if ({ex_control, ex_branch, ex_reg_write, ex_t} !== {4'h6, 2'b10, 32'd20}) begin
         errors++; $display("FAIL beq: got ctl=%h br=%b rw=%b t=%h want 6/1/0/14",
                            ex_control, ex_branch, ex_reg_write, ex_t);
      end
   endtask

   task automatic test_forward();
      drive(rtype(5'd2, 5'd2, 5'd2, 6'h22), 32'd1, 32'd1); step();
      // EX (rd=2) and MEM (rd=2) both match rs=2: EX wins
      drive(rtype(5'd2, 5'd3, 5'd8, 6'h20), 32'd11, 32'd13);
      alu_result = 32'd0; mem_wr_en = 1'b1; mem_rd = 5'd2; mem_data = 32'd9; step();
      checks++; if (ex_s !== 32'd0) begin errors++; $display("FAIL fwd_ex_prio: got %h want 0", ex_s); end
      checks++; if (ex_t !== 32'd13) begin errors++; $display("FAIL fwd_no_match: got %h want d", ex_t); end
      alu_result = 32'd55; step();
      checks++; if (ex_s !== 32'd9) begin errors++; $display("FAIL fwd_mem: got %h want 9", ex_s); end
      drive(rtype(5'd0, 5'd0, 5'd9, 6'h20), 32'd123, 32'd124);
      mem_rd = 5'd0; wb_wr_en = 1'b1; wb_rd = 5'd0; wb_data = 32'd5; step();
      checks++; if ({ex_s, ex_t} !== 64'd0) begin errors++; $display("FAIL fwd_r0: got s=%h t=%h want 0/0", ex_s, ex_t); end
      mem_wr_en = 1'b0;
      drive(rtype(5'd4, 5'd4, 5'd9, 6'h20), 32'd1, 32'd1); wb_rd = 5'd4; wb_data = 32'd66; step();
      checks++; if ({ex_s, ex_t} !== {32'd66, 32'd66}) begin
         errors++; $display("FAIL fwd_wb: got s=%h t=%h want 42/42", ex_s, ex_t); end
      wb_wr_en = 1'b0;
   endtask

   task automatic test_hazard();
      drive(itype(6'h23, 5'd1, 5'd6, 16'd0), 32'd100, 32'd0); step();
      checks++; if ({ex_mem_read, ex_rd, ex_reg_write} !== {1'b1, 5'd6, 1'b1}) begin
         errors++; $display("FAIL lw_dec: got mr=%b rd=%0d rw=%b want 1/6/1", ex_mem_read, ex_rd, ex_reg_write); end
      drive(rtype(5'd6, 5'd6, 5'd7, 6'h20), 32'd1, 32'd1); #2;
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL hz_stall: got %b want 1", id_stall); end
      step();
      checks++; if ({ex_valid, ex_reg_write} !== 2'b00) begin
         errors++; $display("FAIL hz_bubble: got valid=%b rw=%b want 0/0", ex_valid, ex_reg_write); end
      mem_wr_en = 1'b1; mem_rd = 5'd6; mem_data = 32'd42; #2;
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL hz_release: got %b want 0", id_stall); end
      step();
      checks++; if ({ex_valid, ex_s, ex_t, ex_rd} !== {1'b1, 32'd42, 32'd42, 5'd7}) begin
         errors++; $display("FAIL hz_fwd: got v=%b s=%h t=%h rd=%0d want 1/2a/2a/7", ex_valid, ex_s, ex_t, ex_rd); end
      mem_wr_en = 1'b0;
      drive(itype(6'h23, 5'd1, 5'd6, 16'd0), 32'd100, 32'd0); step();
      drive(itype(6'h08, 5'd1, 5'd6, 16'd1), 32'd0, 32'd0); #2;
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL hz_itype_rt: got %b want 0", id_stall); end
      drive(itype(6'h2B, 5'd1, 5'd6, 16'd0), 32'd0, 32'd0); #2;
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL hz_sw_rt: got %b want 1", id_stall); end
      flush = 1'b1; #1;
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL hz_flush_stall: got %b want 0", id_stall); end
      step(); flush = 1'b0;
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL hz_flush_bubble: got %b want 0", ex_valid); end
   endtask

   task automatic test_illegal_hold_flush();
      drive(rtype(5'd1, 5'd2, 5'd3, 6'h3F), 32'd5, 32'd7); step();
      checks++; if ({ex_valid, ex_illegal, ex_reg_write} !== 3'b110) begin
         errors++; $display("FAIL illegal_funct: got v=%b il=%b rw=%b want 1/1/0", ex_valid, ex_illegal, ex_reg_write); end
      drive(itype(6'h3F, 5'd1, 5'd2, 16'd0), 32'd5, 32'd7); step();
      checks++; if ({ex_illegal, ex_control, ex_mem_read, ex_mem_write} !== {1'b1, 4'h0, 2'b00}) begin
         errors++; $display("FAIL illegal_op: got il=%b ctl=%h want 1/0", ex_illegal, ex_control); end
      drive(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7); step();
      hold = 1'b1; drive(rtype(5'd1, 5'd2, 5'd9, 6'h22), 32'd8, 32'd8); #2;
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL hold_stall: got %b want 1", id_stall); end
      step();
      checks++; if ({ex_s, ex_rd, ex_control} !== {32'd5, 5'd3, 4'h2}) begin
         errors++; $display("FAIL hold_keep: got s=%h rd=%0d ctl=%h want 5/3/2", ex_s, ex_rd, ex_control); end
      flush = 1'b1; #1;
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL hold_flush_stall: got %b want 1", id_stall); end
      step();
      checks++; if ({ex_valid, ex_s, ex_rd} !== '0) begin
         errors++; $display("FAIL hold_flush_bubble: got v=%b s=%h rd=%0d want 0", ex_valid, ex_s, ex_rd); end
      hold = 1'b0; flush = 1'b0;
      drive(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7); step();
      id_valid = 1'b0; step();
      checks++; if ({ex_valid, ex_reg_write} !== 2'b00) begin
         errors++; $display("FAIL idle_bubble: got v=%b rw=%b want 0/0", ex_valid, ex_reg_write); end
   endtask

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; id_rs_data = '0; id_rt_data = '0;
      hold = 1'b0; flush = 1'b0; alu_result = '0; mem_wr_en = 1'b0; mem_rd = '0;
      mem_data = '0; wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
      test_reset();
      test_rtype();
      test_imm();
      test_mem_branch();
      test_forward();
      test_hazard();
      test_illegal_hold_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
